// File: rtl/dnn_neuron_bridge.sv
// dnn_neuron_bridge: CPU-side glue between a register file and a single
// hardware neuron. The bridge collects operand slots, launches the neuron,
// waits for its result and writes the sign-extended result back.
module dnn_neuron_bridge #(
    parameter int N_IN = 3,
    parameter int DW   = 16,
    parameter int OPW  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         dnn_sel,
    input  logic [31:0]        instruction,
    input  logic [31:0]        rd3,
    input  logic [31:0]        rd4,
    input  logic [DW-1:0]      y,
    input  logic               neuron_done,
    output logic [N_IN*DW-1:0] x_bus,
    output logic [N_IN*DW-1:0] w_bus,
    output logic [N_IN-1:0]    x_valid,
    output logic [N_IN-1:0]    w_valid,
    output logic               neuron_start,
    output logic               stall,
    output logic               dnn_write,
    output logic [4:0]         wr_addr,
    output logic [31:0]        wr_data,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, BUSY, WB} state_e;
    typedef enum logic [1:0] {CMD_NONE, CMD_LOAD, CMD_FIRE, CMD_CLEAR} cmd_e;

    state_e             state_q, state_d;
    logic [N_IN*DW-1:0] x_bus_q, x_bus_d, w_bus_q, w_bus_d;
    logic [N_IN-1:0]    x_valid_q, x_valid_d, w_valid_q, w_valid_d;
    logic               start_q, start_d, write_q, write_d, err_q, err_d;
    logic [4:0]         wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;

    cmd_e       cmd;
    logic       is_w;
    logic [2:0] idx;
    logic       unused_bits;

    assign cmd  = cmd_e'(dnn_sel);
    assign is_w = instruction[18];
    assign idx  = instruction[17:15];

    // Instruction fields the bridge does not decode.
    assign unused_bits = ^{instruction[31:19], instruction[14:12], instruction[6:0]};

    // Register field bits become the top OPW bits of a DW-wide operand.
    function automatic logic [DW-1:0] to_operand(input logic [31:0] rd);
        logic [DW-1:0] op;
        op = '0;
        op[DW-1 -: OPW] = rd[OPW-1:0];
        return op;
    endfunction

    // Next-state, datapath and output decode for the three-state sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        x_bus_d   = x_bus_q;
        w_bus_d   = w_bus_q;
        x_valid_d = x_valid_q;
        w_valid_d = w_valid_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        write_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                unique case (cmd)
                    CMD_LOAD: begin
                        if (int'(idx) < N_IN) begin
                            // rd3 feeds slot idx, rd4 feeds slot idx+1 if it exists.
                            for (int k = 0; k < N_IN; k++) begin
                                if (k == int'(idx) || k == int'(idx) + 1) begin
                                    if (is_w) begin
                                        w_bus_d[k*DW +: DW] = to_operand(k == int'(idx) ? rd3 : rd4);
                                        w_valid_d[k]        = 1'b1;
                                    end else begin
                                        x_bus_d[k*DW +: DW] = to_operand(k == int'(idx) ? rd3 : rd4);
                                        x_valid_d[k]        = 1'b1;
                                    end
                                end
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    CMD_FIRE: begin
                        // A pending neuron_done is ignored here; fire wins.
                        if (&x_valid_q && &w_valid_q) begin
                            state_d   = BUSY;
                            start_d   = 1'b1;
                            wr_addr_d = instruction[11:7];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    CMD_CLEAR: begin
                        x_valid_d = '0;
                        w_valid_d = '0;
                    end
                    default: ;
                endcase
            end
            BUSY: begin
                err_d = (cmd == CMD_LOAD) || (cmd == CMD_FIRE);
                // Leaving BUSY at once means a held-high done is only used once.
                if (neuron_done) begin
                    wr_data_d = 32'(signed'(y));
                    write_d   = 1'b1;
                    state_d   = WB;
                end
            end
            WB: begin
                err_d     = (cmd == CMD_LOAD) || (cmd == CMD_FIRE);
                x_valid_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            // NOTE: the operand slots are ordinary flops with a defined reset
            // value, not a RAM array, so clearing them on reset is intended.
            x_bus_q   <= '0;
            w_bus_q   <= '0;
            x_valid_q <= '0;
            w_valid_q <= '0;
            start_q   <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            x_bus_q   <= x_bus_d;
            w_bus_q   <= w_bus_d;
            x_valid_q <= x_valid_d;
            w_valid_q <= w_valid_d;
            start_q   <= start_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // stall follows the state so it drops the instant reset lands.
    assign stall        = (state_q != IDLE);
    assign x_bus        = x_bus_q;
    assign w_bus        = w_bus_q;
    assign x_valid      = x_valid_q;
    assign w_valid      = w_valid_q;
    assign neuron_start = start_q;
    assign dnn_write    = write_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign err          = err_q;

endmodule

// File: tb/tb_dnn_neuron_bridge.sv
// Self-checking bench for dnn_neuron_bridge: directed scenarios plus random
// operations, compared against a slot-array reference model.
module tb_dnn_neuron_bridge;

    localparam int N_IN = 3;
    localparam int DW   = 16;
    localparam int OPW  = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         dnn_sel;
    logic [31:0]        instruction, rd3, rd4;
    logic [DW-1:0]      y;
    logic               neuron_done;
    logic [N_IN*DW-1:0] x_bus, w_bus;
    logic [N_IN-1:0]    x_valid, w_valid;
    logic               neuron_start, stall, dnn_write, err;
    logic [4:0]         wr_addr;
    logic [31:0]        wr_data;

    dnn_neuron_bridge #(.N_IN(N_IN), .DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .dnn_sel(dnn_sel), .instruction(instruction),
        .rd3(rd3), .rd4(rd4), .y(y), .neuron_done(neuron_done),
        .x_bus(x_bus), .w_bus(w_bus), .x_valid(x_valid), .w_valid(w_valid),
        .neuron_start(neuron_start), .stall(stall), .dnn_write(dnn_write),
        .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: plain slot arrays plus the last writeback target/data.
    logic [DW-1:0] mx [N_IN];
    logic [DW-1:0] mw [N_IN];
    bit            mxv[N_IN];
    bit            mwv[N_IN];
    logic [4:0]    m_addr;
    logic [31:0]   m_data;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] opnd(input logic [31:0] r);
        longint v;
        v = (longint'(r) % (longint'(1) << OPW)) * (longint'(1) << (DW - OPW));
        return DW'(v);
    endfunction

    function automatic logic [31:0] sext(input logic [DW-1:0] v);
        longint s;
        s = longint'(v);
        if (s >= (longint'(1) << (DW - 1))) s = s - (longint'(1) << DW);
        return 32'(s);
    endfunction

    function automatic logic [N_IN*DW-1:0] pack(input logic [DW-1:0] a[N_IN]);
        logic [N_IN*DW-1:0] p = '0;
        for (int k = 0; k < N_IN; k++) p[k*DW +: DW] = a[k];
        return p;
    endfunction

    function automatic logic [N_IN-1:0] vbits(input bit a[N_IN]);
        logic [N_IN-1:0] p = '0;
        for (int k = 0; k < N_IN; k++) p[k] = a[k];
        return p;
    endfunction

    function automatic bit all_valid();
        bit ok = 1'b1;
        for (int k = 0; k < N_IN; k++) ok = ok & mxv[k] & mwv[k];
        return ok;
    endfunction

    function automatic logic [31:0] load_ins(input bit kind, input int idx);
        logic [31:0] ins = $urandom;
        ins[18]    = kind;
        ins[17:15] = idx[2:0];
        return ins;
    endfunction

    // Drive one cycle of inputs (called on a falling edge), wait a full cycle.
    task automatic cycle(input logic [1:0] sel, input logic [31:0] ins,
                         input logic [31:0] r3, input logic [31:0] r4,
                         input logic done, input logic [DW-1:0] yv);
        dnn_sel = sel; instruction = ins; rd3 = r3; rd4 = r4;
        neuron_done = done; y = yv;
        @(negedge clk);
    endtask

    task automatic check_slots(input string tag);
        check({tag, ".x_bus"},   64'(x_bus),   64'(pack(mx)));
        check({tag, ".w_bus"},   64'(w_bus),   64'(pack(mw)));
        check({tag, ".x_valid"}, 64'(x_valid), 64'(vbits(mxv)));
        check({tag, ".w_valid"}, 64'(w_valid), 64'(vbits(mwv)));
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_IN; k++) begin
            mx[k] = '0; mw[k] = '0; mxv[k] = 1'b0; mwv[k] = 1'b0;
        end
        m_addr = '0; m_data = '0;
    endtask

    task automatic do_load(input bit kind, input int idx, input logic [31:0] r3, input logic [31:0] r4);
        bit bad = (idx >= N_IN);
        cycle(2'd1, load_ins(kind, idx), r3, r4, 1'b0, '0);
        if (!bad) begin
            for (int k = idx; k <= idx + 1 && k < N_IN; k++) begin
                if (kind) begin mw[k] = opnd(k == idx ? r3 : r4); mwv[k] = 1'b1; end
                else      begin mx[k] = opnd(k == idx ? r3 : r4); mxv[k] = 1'b1; end
            end
        end
        check("load.err", 64'(err), 64'(bad));
        check("load.stall", 64'(stall), 64'd0);
        check_slots("load");
    endtask

    task automatic do_clear();
        cycle(2'd3, $urandom, $urandom, $urandom, 1'b0, '0);
        for (int k = 0; k < N_IN; k++) begin mxv[k] = 1'b0; mwv[k] = 1'b0; end
        check("clear.err", 64'(err), 64'd0);
        check_slots("clear");
    endtask

    task automatic fill_all();
        for (int i = 0; i < N_IN; i += 2) begin
            do_load(1'b0, i, $urandom, $urandom);
            do_load(1'b1, i, $urandom, $urandom);
        end
    endtask

    // Full fire transaction; force_load makes the first busy cycle a load.
    task automatic do_fire(input logic [4:0] dst, input bit done_same, input int wait_cyc,
                           input bit force_load, input logic [DW-1:0] yv);
        logic [31:0] ins = $urandom;
        bit ok = all_valid();
        int op;
        ins[11:7] = dst;
        cycle(2'd2, ins, $urandom, $urandom, done_same, $urandom);
        if (!ok) begin
            check("fire_bad.err", 64'(err), 64'd1);
            check("fire_bad.start", 64'(neuron_start), 64'd0);
            check("fire_bad.stall", 64'(stall), 64'd0);
            check_slots("fire_bad");
            return;
        end
        m_addr = dst;
        check("fire.start", 64'(neuron_start), 64'd1);
        check("fire.stall", 64'(stall), 64'd1);
        check("fire.err", 64'(err), 64'd0);
        check("fire.wr_addr", 64'(wr_addr), 64'(m_addr));
        check("fire.write", 64'(dnn_write), 64'd0);
        for (int i = 0; i < wait_cyc; i++) begin
            op = (force_load && i == 0) ? 1 : int'($urandom_range(0, 3));
            cycle(2'(op), load_ins($urandom_range(0, 1), $urandom_range(0, N_IN - 1)),
                  $urandom, $urandom, 1'b0, $urandom);
            check("busy.start", 64'(neuron_start), 64'd0);
            check("busy.stall", 64'(stall), 64'd1);
            check("busy.write", 64'(dnn_write), 64'd0);
            check("busy.err", 64'(err), 64'(op == 1 || op == 2));
            check_slots("busy");
        end
        cycle(2'd0, $urandom, $urandom, $urandom, 1'b1, yv);
        m_data = sext(yv);
        check("wb.write", 64'(dnn_write), 64'd1);
        check("wb.stall", 64'(stall), 64'd1);
        check("wb.wr_data", 64'(wr_data), 64'(m_data));
        check("wb.wr_addr", 64'(wr_addr), 64'(m_addr));
        // done stays high through WB and into IDLE; a load in WB is rejected.
        cycle(2'd1, load_ins(1'b0, 0), $urandom, $urandom, 1'b1, $urandom);
        for (int k = 0; k < N_IN; k++) mxv[k] = 1'b0;
        check("post.write", 64'(dnn_write), 64'd0);
        check("post.stall", 64'(stall), 64'd0);
        check("post.err", 64'(err), 64'd1);
        check_slots("post");
        cycle(2'd0, $urandom, $urandom, $urandom, 1'b1, $urandom);
        check("idle_done.write", 64'(dnn_write), 64'd0);
        check("idle_done.stall", 64'(stall), 64'd0);
        check("idle_done.wr_data", 64'(wr_data), 64'(m_data));
        check_slots("idle_done");
    endtask

    initial begin
        rst = 1'b1; dnn_sel = '0; instruction = '0; rd3 = '0; rd4 = '0;
        y = '0; neuron_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst.start", 64'(neuron_start), 64'd0);
        check("rst.stall", 64'(stall), 64'd0);
        check("rst.write", 64'(dnn_write), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        check("rst.wr_addr", 64'(wr_addr), 64'd0);
        check("rst.wr_data", 64'(wr_data), 64'd0);
        check_slots("rst");
        rst = 1'b0;
        @(negedge clk);

        // Two-slot x load.
        do_load(1'b0, 0, 32'h123, 32'hABC);
        check("ex036.slot0", 64'(x_bus[15:0]), 64'h1230);
        check("ex036.slot1", 64'(x_bus[31:16]), 64'hABC0);
        check("ex036.valid", 64'(x_valid), 64'b011);

        // Fire with incomplete operands.
        do_fire(5'd9, 1'b0, 0, 1'b0, '0);

        // Out-of-range index, then last-slot load touches only that slot.
        do_load(1'b0, 3, $urandom, $urandom);
        do_load(1'b0, 2, 32'h0000_0FED, 32'h5555_5555);
        check("ex039.slot2", 64'(x_bus[47:32]), 64'hFED0);

        // Weights, then the reference fire with a negative result.
        do_load(1'b1, 0, $urandom, $urandom);
        do_load(1'b1, 2, $urandom, $urandom);
        do_fire(5'd9, 1'b0, 2, 1'b1, 16'h8001);
        check("ex037.wr_data", 64'(wr_data), 64'hFFFF8001);
        check("ex037.w_valid", 64'(w_valid), 64'b111);

        // Weights retained: refill x only, fire with done in the same cycle.
        do_load(1'b0, 0, $urandom, $urandom);
        do_load(1'b0, 1, $urandom, $urandom);
        do_fire(5'd17, 1'b1, 1, 1'b0, 16'h7FFF);

        // Random mix of loads, clears and fires.
        for (int it = 0; it < 60; it++) begin
            int sel = $urandom_range(0, 9);
            if (it % 15 == 14)  fill_all();
            if (sel < 6)        do_load($urandom_range(0, 1), $urandom_range(0, 4), $urandom, $urandom);
            else if (sel == 6)  do_clear();
            else                do_fire(5'($urandom), $urandom_range(0, 1),
                                        $urandom_range(0, 3), 1'b0, DW'($urandom));
        end

        // Reset in the middle of a busy operation.
        fill_all();
        cycle(2'd2, 32'h0000_0280, '0, '0, 1'b0, '0);
        check("rstbusy.pre_stall", 64'(stall), 64'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rstbusy.stall", 64'(stall), 64'd0);
        check("rstbusy.start", 64'(neuron_start), 64'd0);
        check("rstbusy.wr_addr", 64'(wr_addr), 64'd0);
        check_slots("rstbusy");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(2'd0, '0, '0, '0, 1'b1, 16'h1234);
            check("rstbusy.write", 64'(dnn_write), 64'd0);
            check("rstbusy.stall_after", 64'(stall), 64'd0);
            check("rstbusy.wr_data", 64'(wr_data), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
